// File: rtl/pipelined_rca_if.sv
// pipelined_rca_if: operation/result handshake bundle for pipelined_rca.
//   master : drives the operation (in_valid, a, b, cin, sub) and out_ready;
//            observes in_ready and the result (out_valid, sum, cout, ovf).
//   slave  : the adder side of the same bundle.
interface pipelined_rca_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_rca.sv
// pipelined_rca: pipelined ripple-carry adder/subtractor.
// The WIDTH-bit operands are cut into STAGES chunks of CHUNK bits. Stage k ripples chunk k using
// the carry registered by stage k-1; stage 0 works directly on the incoming operands, so a result
// leaves STAGES cycles after it is accepted. One op per cycle, valid/ready with backpressure.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, drops all in-flight operations
//   bus    : pipelined_rca_if.slave (in_valid/in_ready/a/b/cin/sub, out_valid/out_ready/sum/cout/ovf)
module pipelined_rca #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  pipelined_rca_if.slave bus
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_rca: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic advance;

  // Per-stage state. a/b hold the not-yet-added upper chunks (skew), sum holds the finished
  // lower chunks (deskew); unused bit ranges in each stage are simply don't-care.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [WIDTH-1:0]  op_a_q [STAGES];
  logic [WIDTH-1:0]  op_a_d [STAGES];
  logic [WIDTH-1:0]  op_b_q [STAGES];
  logic [WIDTH-1:0]  op_b_d [STAGES];
  logic [WIDTH-1:0]  sum_q  [STAGES];
  logic [WIDTH-1:0]  sum_d  [STAGES];
  logic              ovf_q, ovf_d;

  // What each stage sees as its predecessor.
  logic [STAGES-1:0] src_v, src_c;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];

  logic [CHUNK:0]    chain [STAGES];
  logic [WIDTH-1:0]  res_s [STAGES];
  logic              msb_cin, msb_cout;

  assign advance = ~vld_q[STAGES-1] | bus.out_ready;

  always_comb begin
    // Subtraction folds into an add: invert b and the borrow-in at capture.
    src_v[0] = bus.in_valid;
    src_c[0] = bus.cin ^ bus.sub;
    src_a[0] = bus.a;
    src_b[0] = bus.b ^ {WIDTH{bus.sub}};
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = vld_q[k-1];
      src_c[k] = cy_q[k-1];
      src_a[k] = op_a_q[k-1];
      src_b[k] = op_b_q[k-1];
      src_s[k] = sum_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      chain[k][0] = src_c[k];
      res_s[k]    = src_s[k];
      for (int i = 0; i < CHUNK; i++) begin
        res_s[k][k*CHUNK+i] = src_a[k][k*CHUNK+i] ^ src_b[k][k*CHUNK+i] ^ chain[k][i];
        chain[k][i+1]       = (src_a[k][k*CHUNK+i] & src_b[k][k*CHUNK+i]) |
                              (chain[k][i] & (src_a[k][k*CHUNK+i] ^ src_b[k][k*CHUNK+i]));
      end
    end
  end

  // Carry into / out of the MSB both live in the last stage's chunk.
  assign msb_cin  = chain[STAGES-1][CHUNK-1];
  assign msb_cout = chain[STAGES-1][CHUNK];

  always_comb begin
    vld_d = vld_q;
    cy_d  = cy_q;
    ovf_d = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      op_a_d[k] = op_a_q[k];
      op_b_d[k] = op_b_q[k];
      sum_d[k]  = sum_q[k];
    end
    if (advance) begin
      vld_d = src_v;
      ovf_d = msb_cin ^ msb_cout;
      for (int k = 0; k < STAGES; k++) begin
        cy_d[k]   = chain[k][CHUNK];
        op_a_d[k] = src_a[k];
        op_b_d[k] = src_b[k];
        sum_d[k]  = res_s[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        op_a_q[k] <= '0;
        op_b_q[k] <= '0;
        sum_q[k]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        op_a_q[k] <= op_a_d[k];
        op_b_q[k] <= op_b_d[k];
        sum_q[k]  <= sum_d[k];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = cy_q[STAGES-1];
  assign bus.ovf       = ovf_q;

endmodule
